// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Brief    : 640x480@60 VGA sequencer: sync generation, one-ahead pixel
//            request and registered RGB, started/stopped on frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pix_ce,
    input  logic        enable,
    input  logic [15:0] pix_data,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start,
    output logic        busy
);

    localparam int         c_H_TOTAL   = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int         c_V_TOTAL   = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam logic [9:0] c_H_LAST    = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST    = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_OFS     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] c_V_OFS     = 10'(V_SYNC + V_BACK);
    // 11-bit bounds so an active window ending at 1024 still compares correctly
    localparam logic [10:0] c_H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] c_V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] c_H_ACT_LO = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] c_H_ACT_HI = 11'(H_SYNC + H_BACK + H_VALID);
    localparam logic [10:0] c_V_ACT_LO = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] c_V_ACT_HI = 11'(V_SYNC + V_BACK + V_VALID);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_RUN      = 2'd1;
    localparam logic [1:0] c_ST_STOPPING = 2'd2;

    function automatic logic [9:0] f_h_succ(input logic [9:0] h);
        return (h == c_H_LAST) ? 10'd0 : h + 10'd1;
    endfunction

    function automatic logic [9:0] f_v_succ(input logic [9:0] h, input logic [9:0] v);
        if (h != c_H_LAST) return v;
        return (v == c_V_LAST) ? 10'd0 : v + 10'd1;
    endfunction

    function automatic logic f_active(input logic [9:0] h, input logic [9:0] v);
        return ({1'b0, h} >= c_H_ACT_LO) && ({1'b0, h} < c_H_ACT_HI) &&
               ({1'b0, v} >= c_V_ACT_LO) && ({1'b0, v} < c_V_ACT_HI);
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [9:0]  w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic [9:0]  w_h_ahead;
    logic [9:0]  w_v_ahead;
    logic        w_at_last;
    logic        w_run_nxt;
    logic        w_req_nxt;
    logic        w_valid_nxt;

    logic        r_pix_req;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_rgb_valid;
    logic [15:0] r_rgb;
    logic        r_frame_start;
    logic        r_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_ST_IDLE;
        end else if (pix_ce) begin
            r_state <= w_state_nxt;
        end
    end

    assign w_at_last = (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_LAST);

    // A frame in progress always completes; enable only decides what follows it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (enable) w_state_nxt = c_ST_RUN;
            c_ST_RUN:      if (!enable) w_state_nxt = w_at_last ? c_ST_IDLE : c_ST_STOPPING;
            c_ST_STOPPING: begin
                if (enable)         w_state_nxt = c_ST_RUN;
                else if (w_at_last) w_state_nxt = c_ST_IDLE;
            end
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_run_nxt = (w_state_nxt != c_ST_IDLE);
        w_h_nxt   = 10'd0;
        w_v_nxt   = 10'd0;
        if (w_run_nxt && (r_state != c_ST_IDLE)) begin
            w_h_nxt = f_h_succ(r_h_cnt);
            w_v_nxt = f_v_succ(r_h_cnt, r_v_cnt);
        end
        // Request is for the position one pixel beyond the one being entered
        w_h_ahead   = f_h_succ(w_h_nxt);
        w_v_ahead   = f_v_succ(w_h_nxt, w_v_nxt);
        w_req_nxt   = w_run_nxt && f_active(w_h_ahead, w_v_ahead);
        w_valid_nxt = w_run_nxt && f_active(w_h_nxt, w_v_nxt);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_pix_req     <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb_valid   <= 1'b0;
            r_rgb         <= 16'd0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else if (pix_ce) begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_pix_req     <= w_req_nxt;
            r_pix_x       <= w_req_nxt ? (w_h_ahead - c_H_OFS) : 10'd0;
            r_pix_y       <= w_req_nxt ? (w_v_ahead - c_V_OFS) : 10'd0;
            r_hsync       <= !(w_run_nxt && ({1'b0, w_h_nxt} < c_H_SYNC_W));
            r_vsync       <= !(w_run_nxt && ({1'b0, w_v_nxt} < c_V_SYNC_W));
            r_rgb_valid   <= w_valid_nxt;
            r_rgb         <= w_valid_nxt ? pix_data : 16'd0;
            r_frame_start <= w_run_nxt && (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
            r_busy        <= w_run_nxt;
        end
    end

    assign pix_req     = r_pix_req;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_valid   = r_rgb_valid;
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Brief    : Randomized self-checking bench for vga_timing_ctrl against a
//            frame-position reference model, on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    localparam int HS = 4, HB = 3, HV = 10, HF = 2;
    localparam int VS = 2, VB = 2, VV = 6,  VF = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FRAME = HT * VT;
    localparam int HO = HS + HB;
    localparam int VO = VS + VB;
    localparam logic [41:0] c_RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 16'd0};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        pix_ce;
    logic        enable;
    logic [15:0] pix_data;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
    logic        frame_start;
    logic        busy;

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pix_ce     (pix_ce),
        .enable     (enable),
        .pix_data   (pix_data),
        .pix_req    (pix_req),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb_valid  (rgb_valid),
        .rgb        (rgb),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: running flag plus linear position within the frame
    bit          m_busy;
    int          m_pos;
    logic [15:0] m_rgb;

    bit data_mode;
    bit regular;

    int          mon_ce, mon_clk, mon_hlow, mon_vlow, mon_valid, mon_hpulses;
    bit          mon_have, mon_cont, mon_regular, mon_data, mon_seen;
    bit          prev_h;
    logic [15:0] mon_first, mon_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit f_act(input int pos);
        int h = pos % HT;
        int v = pos / HT;
        return (h >= HO) && (h < HO + HV) && (v >= VO) && (v < VO + VV);
    endfunction

    function automatic logic [41:0] f_exp();
        int h, v, np;
        bit act, req;
        logic [9:0] ex, ey;
        h   = m_pos % HT;
        v   = m_pos / HT;
        np  = (m_pos + 1) % FRAME;
        act = m_busy && f_act(m_pos);
        req = m_busy && f_act(np);
        ex  = req ? 10'((np % HT) - HO) : 10'd0;
        ey  = req ? 10'((np / HT) - VO) : 10'd0;
        return {m_busy, m_busy && (m_pos == 0), !(m_busy && (h < HS)), !(m_busy && (v < VS)),
                act, req, ex, ey, m_rgb};
    endfunction

    function automatic logic [41:0] f_obs();
        return {busy, frame_start, hsync, vsync, rgb_valid, pix_req, pix_x, pix_y, rgb};
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_pos    = 0;
        m_rgb    = 16'd0;
        mon_have = 1'b0;
        prev_h   = 1'b1;
    endtask

    task automatic model_edge(input bit ce, input bit en, input logic [15:0] d);
        if (!ce) return;
        if (!m_busy) begin
            if (en) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end else if ((m_pos == FRAME - 1) && !en) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        m_rgb = (m_busy && f_act(m_pos)) ? d : 16'd0;
    endtask

    // Frame-level measurements between consecutive frame_start pulses
    task automatic monitor(input bit ce);
        mon_clk++;
        if (!regular)   mon_regular = 1'b0;
        if (!data_mode) mon_data    = 1'b0;
        if (!ce) return;
        if (frame_start) begin
            if (mon_have && mon_cont) begin
                check_eq("frame_ce", 64'(mon_ce), 64'(FRAME));
                check_eq("hsync_low", 64'(mon_hlow), 64'(VT * HS));
                check_eq("hsync_pulses", 64'(mon_hpulses), 64'(VT));
                check_eq("vsync_low", 64'(mon_vlow), 64'(VS * HT));
                check_eq("valid_count", 64'(mon_valid), 64'(HV * VV));
                if (mon_regular) check_eq("frame_clk", 64'(mon_clk), 64'(2 * FRAME));
                if (mon_data) begin
                    check_eq("first_rgb", 64'(mon_first), 64'(16'h0000));
                    check_eq("last_rgb", 64'(mon_last), 64'({6'(VV - 1), 10'(HV - 1)}));
                end
            end
            mon_have = 1'b1; mon_cont = 1'b1; mon_regular = 1'b1; mon_data = data_mode;
            mon_seen = 1'b0;
            mon_ce = 0; mon_clk = 0; mon_hlow = 0; mon_vlow = 0; mon_valid = 0; mon_hpulses = 0;
        end
        mon_ce++;
        if (!hsync) mon_hlow++;
        if (!hsync && prev_h) mon_hpulses++;
        if (!vsync) mon_vlow++;
        if (rgb_valid) begin
            mon_valid++;
            if (!mon_seen) mon_first = rgb;
            mon_seen = 1'b1;
            mon_last = rgb;
        end
        if (!busy) mon_cont = 1'b0;
        prev_h = hsync;
    endtask

    task automatic step(input bit ce, input bit en);
        logic [15:0] d;
        d = data_mode ? {pix_y[5:0], pix_x} : 16'($urandom);
        pix_ce = ce; enable = en; pix_data = d;
        @(posedge sys_clk);
        model_edge(ce, en, d);
        #1;
        check_eq("outputs", 64'(f_obs()), 64'(f_exp()));
        monitor(ce);
    endtask

    task automatic pulse(input bit en, input int gap);
        for (int g = 0; g < gap; g++) step(1'b0, en);
        step(1'b1, en);
    endtask

    task automatic run_to_pos(input bit en, input int pos);
        for (int i = 0; i < 2 * FRAME && !(m_busy && m_pos == pos); i++) pulse(en, 1);
        check_eq("reach_pos", 64'(m_pos), 64'(pos));
    endtask

    initial begin
        int n, drop_pos;
        bit en_r;
        sys_rst_n = 1'b0; pix_ce = 1'b0; enable = 1'b0; pix_data = 16'd0;
        data_mode = 1'b0; regular = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("reset", 64'(f_obs()), 64'(c_RST_VEC));
        sys_rst_n = 1'b1;

        for (int i = 0; i < 500; i++) pulse(1'b0, 1);
        check_eq("idle_busy", 64'(busy), 64'(0));

        // Regular pix_ce with feedback pixel source
        regular = 1'b1; data_mode = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) pulse(1'b1, 1);

        // Stop request mid-frame
        run_to_pos(1'b1, 3 * HT);
        drop_pos = m_pos;
        n = 0;
        while (busy && n < 2 * FRAME) begin
            pulse(1'b0, 1);
            n++;
        end
        check_eq("stop_len", 64'(n), 64'(FRAME - drop_pos));
        check_eq("stop_sync", 64'({hsync, vsync}), 64'(2'b11));
        for (int i = 0; i < 20; i++) pulse(1'b0, 1);

        // Re-enable while stopping
        run_to_pos(1'b1, 3 * HT);
        for (int i = 0; i < 2 * FRAME && m_pos != 7 * HT; i++) pulse(1'b0, 1);
        check_eq("stopping_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 2 * FRAME; i++) pulse(1'b1, 1);

        // Irregular pix_ce, random data
        regular = 1'b0; data_mode = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) pulse(1'b1, $urandom_range(0, 5));

        // Random enable toggling with irregular pix_ce
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = !en_r;
            data_mode = ($urandom_range(0, 3) == 0);
            pulse(en_r, $urandom_range(0, 5));
        end

        // Asynchronous reset in the middle of a frame
        data_mode = 1'b0;
        run_to_pos(1'b1, 5 * HT + 9);
        check_eq("pre_rst_busy", 64'(busy), 64'(1));
        #2 sys_rst_n = 1'b0;
        #1 check_eq("async_rst", 64'(f_obs()), 64'(c_RST_VEC));
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        for (int i = 0; i < 500; i++) pulse(1'b0, 1);
        check_eq("post_rst_idle", 64'({busy, hsync, vsync}), 64'(3'b011));
        regular = 1'b1;
        for (int i = 0; i < 2 * FRAME + 2; i++) pulse(1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
